// File: rtl/mem_scan_ctrl_if.sv
// Purpose: bundles the control inputs and display outputs of mem_scan_ctrl.
// Signals:
//   we, start, abort : single-cycle pulses from debounced buttons
//   mode[1:0]        : 00 manual, 01 scan, 10 fill, 11 clear
//   addr[AW-1:0]     : manual address / scan start address
//   din[DW-1:0]      : write data / fill seed
//   dout, cur_addr   : registered read data and the address it belongs to
//   busy, done, scan_step : status
//   mismatch_cnt[15:0] : only with MEM_SCAN_CHECK_EN defined
// Modports: master drives the controls, slave is the controller itself.
interface mem_scan_ctrl_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 4
);
  logic          we;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [AW-1:0] cur_addr;
  logic          busy;
  logic          done;
  logic          scan_step;
`ifdef MEM_SCAN_CHECK_EN
  logic [15:0]   mismatch_cnt;

  modport master (
    output we, start, abort, mode, addr, din,
    input  dout, cur_addr, busy, done, scan_step, mismatch_cnt
  );
  modport slave (
    input  we, start, abort, mode, addr, din,
    output dout, cur_addr, busy, done, scan_step, mismatch_cnt
  );
`else
  modport master (
    output we, start, abort, mode, addr, din,
    input  dout, cur_addr, busy, done, scan_step
  );
  modport slave (
    input  we, start, abort, mode, addr, din,
    output dout, cur_addr, busy, done, scan_step
  );
`endif
endinterface

// File: rtl/mem_scan_ctrl.sv
// Purpose: DEPTH x DW single-port RAM with a control FSM for manual
// read/write, timed auto-scan, pattern fill and clear.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (RAM contents are not reset)
//   bus     : mem_scan_ctrl_if.slave (controls in, dout/cur_addr/status out)
// Optional: define MEM_SCAN_CHECK_EN to add bus.mismatch_cnt, counting scan
// reads that differ from din (saturating, cleared on scan entry).
module mem_scan_ctrl #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 4,
  parameter int unsigned SCAN_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_scan_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FILL, ST_CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          step_q, step_d;

  logic [DW-1:0] mem [DEPTH];
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_wdata_c;
  logic [DW-1:0] ram_rdata_c;

  assign ram_rdata_c = mem[ram_addr_c];

  // Next-state, RAM port and output logic
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    seed_d      = seed_q;
    div_d       = div_q;
    done_d      = 1'b0;
    step_d      = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = cur_addr_q;
    ram_wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        // Manual access goes straight to the requested address
        cur_addr_d  = bus.addr;
        ram_addr_c  = bus.addr;
        ram_we_c    = bus.we;
        ram_wdata_c = bus.din;
        if (bus.start) begin
          case (bus.mode)
            2'b01: begin
              state_d    = ST_SCAN;
              cur_addr_d = bus.addr;
              div_d      = '0;
            end
            2'b10: begin
              state_d    = ST_FILL;
              cur_addr_d = '0;
              seed_d     = bus.din;
            end
            2'b11: begin
              state_d    = ST_CLEAR;
              cur_addr_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SCAN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          cur_addr_d = cur_addr_q + AW'(1);
          step_d     = 1'b1;
          div_d      = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        // FILL and CLEAR: one word per cycle; the abort-cycle write still lands
        ram_we_c    = 1'b1;
        ram_wdata_c = (state_q == ST_FILL) ? DW'(seed_q + DW'(cur_addr_q)) : '0;
        cur_addr_d  = cur_addr_q + AW'(1);
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (cur_addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    // Write-first: written data appears on dout the following cycle
    dout_d = ram_we_c ? ram_wdata_c : ram_rdata_c;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      dout_q     <= '0;
      seed_q     <= '0;
      div_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      dout_q     <= dout_d;
      seed_q     <= seed_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
    end
  end

  // RAM array, no reset
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[ram_addr_c] <= ram_wdata_c;
  end

  assign bus.dout      = dout_q;
  assign bus.cur_addr  = cur_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.scan_step = step_q;

`ifdef MEM_SCAN_CHECK_EN
  logic [15:0] mis_q, mis_d;
  logic        chk_q, chk_d;

  // chk_q marks the scan cycles in which dout is reloaded after an address change
  always_comb begin
    mis_d = mis_q;
    chk_d = (state_d == ST_SCAN) && ((state_q != ST_SCAN) || step_d);
    if (state_q == ST_IDLE && state_d == ST_SCAN) begin
      mis_d = '0;
    end else if (state_q == ST_SCAN && chk_q && (ram_rdata_c != bus.din)
                 && (mis_q != 16'hFFFF)) begin
      mis_d = mis_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_q <= '0;
      chk_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      chk_q <= chk_d;
    end
  end

  assign bus.mismatch_cnt = mis_q;
`endif
endmodule

// File: tb/tb_mem_scan_ctrl.sv
module tb_mem_scan_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_scan_ctrl_if #(.AW(4), .DW(4)) bus ();

  mem_scan_ctrl #(.AW(4), .DW(4), .SCAN_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic       we;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [3:0] addr;
    logic [3:0] din;
    logic [3:0] exp_cur;
    logic [3:0] exp_dout;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] exp, input string nm);
    bus.addr = a;
    bus.we   = 1'b0;
    tick();
    chk(nm, 32'(bus.dout), 32'(exp));
  endtask

  initial begin
    int busy_cnt, done_cnt, done_cyc;
    logic [3:0] prev_cur, exp_cur;

    //  we start abort mode addr din  cur dout busy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd3, 4'd9, 4'd3, 4'd9, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd4, 4'd6, 4'd4, 4'd6, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 4'd0, 4'd3, 4'd9, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd0, 4'd4, 4'd6, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd4, 4'd2, 4'd4, 4'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 4'd0, 4'd3, 4'd9, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd0, 4'd4, 4'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'd4, 4'd0, 4'd4, 4'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd3, 4'd0, 4'd3, 4'd9, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'b01, 4'd3, 4'd0, 4'd3, 4'd9, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b10, 4'd3, 4'd0, 4'd3, 4'd9, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd0, 4'd4, 4'd2, 1'b0};

    reset_n   = 1'b0;
    bus.we    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 2'b00;
    bus.addr  = '0;
    bus.din   = '0;
    tick();
    tick();
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_cur", 32'(bus.cur_addr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_step", 32'(bus.scan_step), 0);
`ifdef MEM_SCAN_CHECK_EN
    chk("rst_mis", 32'(bus.mismatch_cnt), 0);
`endif
    reset_n = 1'b1;

    // Manual access vectors
    for (int i = 0; i < 12; i++) begin
      bus.we    = vecs[i].we;
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      bus.mode  = vecs[i].mode;
      bus.addr  = vecs[i].addr;
      bus.din   = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_cur", i), 32'(bus.cur_addr), 32'(vecs[i].exp_cur));
      chk($sformatf("vec%0d_dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
    end
    bus.we = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;

    // FILL with seed 5
    bus.mode = 2'b10; bus.din = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int i = 1; i <= 24; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_cyc = i; end
      bus.we = (i == 4);
      bus.din = (i == 4) ? 4'd0 : 4'd5;
      tick();
    end
    bus.we = 1'b0;
    chk("fill_busy_cycles", 32'(busy_cnt), 16);
    chk("fill_done_count", 32'(done_cnt), 1);
    chk("fill_done_cycle", 32'(done_cyc), 17);
    rd(4'd0, 4'd5, "fill_mem0");
    rd(4'd3, 4'd8, "fill_mem3");
    rd(4'd10, 4'd15, "fill_mem10");
    rd(4'd15, 4'd4, "fill_mem15");

    // SCAN from 14, with a we pulse and a start pulse while busy
    bus.mode = 2'b01; bus.addr = 4'd14; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    prev_cur = 4'd14;
    for (int i = 1; i <= 16; i++) begin
      exp_cur = 4'(14 + (i - 1) / 4);
      chk($sformatf("scan%0d_cur", i), 32'(bus.cur_addr), 32'(exp_cur));
      chk($sformatf("scan%0d_step", i), 32'(bus.scan_step),
          32'((i > 1) && ((i - 1) % 4 == 0)));
      chk($sformatf("scan%0d_dout", i), 32'(bus.dout), 32'(4'(5 + prev_cur)));
      chk($sformatf("scan%0d_busy", i), 32'(bus.busy), 1);
      prev_cur  = exp_cur;
      bus.we    = (i == 3);
      bus.addr  = (i == 3) ? 4'd2 : 4'd14;
      bus.din   = (i == 3) ? 4'd0 : 4'd5;
      bus.start = (i == 7);
      bus.mode  = (i == 7) ? 2'b10 : 2'b01;
      tick();
    end
    bus.we = 1'b0; bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("scan_abort_busy", 32'(bus.busy), 0);
    chk("scan_abort_done", 32'(bus.done), 0);
    rd(4'd2, 4'd7, "scan_we_ignored");
    rd(4'd14, 4'd3, "scan_mem14");

    // CLEAR aborted on busy cycle 6
    bus.mode = 2'b11; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("clr%0d_busy", i), 32'(bus.busy), 1);
      if (bus.done) done_cnt++;
      bus.abort = (i == 6);
      tick();
    end
    bus.abort = 1'b0;
    chk("clr_abort_busy", 32'(bus.busy), 0);
    if (bus.done) done_cnt++;
    tick();
    if (bus.done) done_cnt++;
    chk("clr_no_done", 32'(done_cnt), 0);
    for (int k = 0; k < 16; k++) begin
      rd(4'(k), (k < 6) ? 4'd0 : 4'(5 + k), $sformatf("clr_mem%0d", k));
    end

    // Asynchronous reset in the middle of a fill
    bus.mode = 2'b10; bus.din = 4'd1; bus.addr = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dout", 32'(bus.dout), 0);
    chk("arst_cur", 32'(bus.cur_addr), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_step", 32'(bus.scan_step), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("arst_idle", 32'(bus.busy), 0);

    // Fill seed 0 after reset release
    bus.mode = 2'b10; bus.din = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    chk("fill0_done_count", 32'(done_cnt), 1);
    rd(4'd0, 4'd0, "fill0_mem0");
    rd(4'd9, 4'd9, "fill0_mem9");
    rd(4'd15, 4'd15, "fill0_mem15");

`ifdef MEM_SCAN_CHECK_EN
    // Scan all 16 steps against din=0: only address 0 matches
    bus.mode = 2'b01; bus.addr = 4'd0; bus.din = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 65; i++) tick();
    chk("mis_after_16_steps", 32'(bus.mismatch_cnt), 15);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("mis_cleared", 32'(bus.mismatch_cnt), 0);
    tick();
    chk("mis_addr0_match", 32'(bus.mismatch_cnt), 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
